uart_cmd_ctrl: RTL

//  Command/response sequencer that sits on top of the UART (tx + rx pair).
//  - Assembles NUM_BYTES received bytes, MSB byte first, into one command word.
//  - Presents the word with a cmd_rdy/clr_cmd_rdy handshake.
//  - Sequences single-byte responses onto the transmitter.
//  - Guards against partial frames (inter-byte timeout) and overrun.

---
 rtl/uart_ctrl_pkg.sv | 9 +
 rtl/uart_cmd_assembler.sv | 100 ++++++++++
 rtl/uart_cmd_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared FSM state types, command-width helper and default frame timeout
package uart_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, VALID} rx_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;
  localparam int unsigned TIMEOUT_CLKS_DEF = 65536;
  function automatic int unsigned cmd_w(input int unsigned n);
    return 8 * n;
  endfunction
endpackage

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: packs NUM_BYTES rx bytes (MSB first) into a command word with timeout and overrun guard
//   in : clk_i, rst_ni, rdy_i, rx_data_i[8], clr_cmd_rdy_i
//   out: clr_rdy_o (comb), cmd_o[8*NUM_BYTES], cmd_rdy_o, overrun_o (sticky), frame_err_o (pulse)
module uart_cmd_assembler
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = 2,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rdy_i,
  input  logic [7:0]             rx_data_i,
  output logic                   clr_rdy_o,
  output logic [8*NUM_BYTES-1:0] cmd_o,
  output logic                   cmd_rdy_o,
  input  logic                   clr_cmd_rdy_i,
  output logic                   overrun_o,
  output logic                   frame_err_o
);
  localparam int unsigned CMD_W = cmd_w(NUM_BYTES);
  localparam int unsigned TW    = $clog2(TIMEOUT_CLKS);
  rx_state_t        state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d, shifted;
  logic [2:0]       cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             rdy_q, rdy_d, ovr_q, ovr_d, ferr_q, ferr_d;
  assign shifted     = {cmd_q[CMD_W-9:0], rx_data_i};
  assign cmd_o       = cmd_q;
  assign cmd_rdy_o   = rdy_q;
  assign overrun_o   = ovr_q;
  assign frame_err_o = ferr_q;
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    rdy_d     = rdy_q;
    ovr_d     = ovr_q;
    ferr_d    = 1'b0;
    clr_rdy_o = 1'b0;
    case (state_q)
      IDLE: if (rdy_i) begin
        clr_rdy_o = 1'b1;
        cmd_d     = shifted;
        cnt_d     = 3'd1;
        tmo_d     = '0;
        state_d   = COLLECT;
      end
      COLLECT: if (rdy_i) begin
        clr_rdy_o = 1'b1;
        cmd_d     = shifted;
        tmo_d     = '0;
        cnt_d     = cnt_q == 3'(NUM_BYTES - 1) ? 3'd0 : cnt_q + 3'd1;
        rdy_d     = cnt_q == 3'(NUM_BYTES - 1);
        state_d   = cnt_q == 3'(NUM_BYTES - 1) ? VALID : COLLECT;
      end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
        ferr_d  = 1'b1;
        cnt_d   = 3'd0;
        tmo_d   = '0;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      VALID: if (clr_cmd_rdy_i) begin
        // Ack wins over a coincident byte, which then opens the next frame.
        rdy_d     = 1'b0;
        ovr_d     = 1'b0;
        clr_rdy_o = rdy_i;
        cmd_d     = rdy_i ? shifted : cmd_q;
        cnt_d     = rdy_i ? 3'd1 : 3'd0;
        tmo_d     = '0;
        state_d   = rdy_i ? COLLECT : IDLE;
      end else if (rdy_i) begin
        clr_rdy_o = 1'b1;
        ovr_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART command/response sequencer (rx command assembly + single-byte tx responses)
//   rx : rdy_i, rx_data_i -> clr_rdy_o, cmd_o, cmd_rdy_o, overrun_o, frame_err_o; ack via clr_cmd_rdy_i
//   tx : resp_i, send_resp_i, tx_done_i -> trmt_o, tx_data_o, resp_busy_o, resp_sent_o
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = 2,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rdy_i,
  input  logic [7:0]             rx_data_i,
  output logic                   clr_rdy_o,
  output logic [8*NUM_BYTES-1:0] cmd_o,
  output logic                   cmd_rdy_o,
  input  logic                   clr_cmd_rdy_i,
  output logic                   overrun_o,
  output logic                   frame_err_o,
  input  logic [7:0]             resp_i,
  input  logic                   send_resp_i,
  output logic                   resp_busy_o,
  output logic                   resp_sent_o,
  output logic                   trmt_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_done_i
);
  tx_state_t  tx_state_q, tx_state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       trmt_q, trmt_d, busy_q, busy_d, sent_q, sent_d, done_q;
  uart_cmd_assembler #(.NUM_BYTES(NUM_BYTES), .TIMEOUT_CLKS(TIMEOUT_CLKS)) u_asm (
    .clk_i(clk_i), .rst_ni(rst_ni), .rdy_i(rdy_i), .rx_data_i(rx_data_i),
    .clr_rdy_o(clr_rdy_o), .cmd_o(cmd_o), .cmd_rdy_o(cmd_rdy_o),
    .clr_cmd_rdy_i(clr_cmd_rdy_i), .overrun_o(overrun_o), .frame_err_o(frame_err_o)
  );
  assign trmt_o      = trmt_q;
  assign tx_data_o   = tx_data_q;
  assign resp_busy_o = busy_q;
  assign resp_sent_o = sent_q;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    busy_d     = busy_q;
    sent_d     = 1'b0;
    case (tx_state_q)
      // A request landing on the resp_sent cycle is dropped; the caller retries.
      TX_IDLE: if (send_resp_i && !sent_q) begin
        tx_data_d  = resp_i;
        trmt_d     = 1'b1;
        busy_d     = 1'b1;
        tx_state_d = TX_WAIT;
      end
      // Only a fresh rising edge completes, so a stale done level is ignored.
      TX_WAIT: if (tx_done_i && !done_q) begin
        sent_d     = 1'b1;
        busy_d     = 1'b0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= '0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
      done_q     <= tx_done_i;
    end
  end
endmodule
